// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_JALWB  = 4'd12,
    S_LUI    = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // funct3 010/011 are not defined for conditional branches.
  function automatic logic branch_f3_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

endpackage

// File: rtl/multicycle_cu_if.sv
// Shared instruction/data memory port. A request is outstanding while
// mem_req=1 and completes in the cycle the memory drives mem_ready=1.
interface multicycle_cu_if;
  logic mem_req;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input MemWrite, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 to an ALU operation for register and immediate ALU ops.
module alu_decoder
  import cu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       is_rtype_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (funct3_i)
      3'b000: alu_ctrl_o = (is_rtype_i && funct7_i) ? ALU_SUB : ALU_ADD;
      3'b001: alu_ctrl_o = ALU_SLL;
      3'b010: alu_ctrl_o = ALU_SLT;
      3'b011: alu_ctrl_o = ALU_SLTU;
      3'b100: alu_ctrl_o = ALU_XOR;
      3'b101: alu_ctrl_o = funct7_i ? ALU_SRA : ALU_SRL;
      3'b110: alu_ctrl_o = ALU_OR;
      default: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/
// writeback over a req/ready memory port and traps on illegal ops or timeouts.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 EQ,
  input  logic                 LT,
  input  logic                 LTU,
  multicycle_cu_if.master      mem,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [2:0]           ImmSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic [1:0]           ResultSrc,
  output logic                 RegWrite,
  output logic                 fault,
  output logic [3:0]           state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       alu_dec;
  logic [3:0]       alu_sel;
  logic             mem_req_c, mem_write_c;
  logic             wait_st, timeout, taken;

  alu_decoder u_alu_dec (
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .is_rtype_i (state_q == S_EXECR),
    .alu_ctrl_o (alu_dec)
  );

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = (MEM_TIMEOUT != 0) && wait_st && !mem.mem_ready &&
                   (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = EQ;
      3'b001: taken = !EQ;
      3'b100: taken = LT;
      3'b101: taken = !LT;
      3'b110: taken = LTU;
      3'b111: taken = !LTU;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    ImmSrc      = IMM_I;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    alu_sel     = ALU_ADD;
    ResultSrc   = RES_ALUOUT;
    RegWrite    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem.mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/JAL target is computed here and parked in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = branch_f3_legal(funct3) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        AdrSrc      = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        alu_sel = alu_dec;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        alu_sel = ALU_SUB;
        PCWrite = taken;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
        state_d   = S_JALWB;
      end
      S_JALWB: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_LUI: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        alu_sel = ALU_PASSB;
        state_d = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
    // A late mem_ready in the final allowed cycle still completes normally.
    if (timeout) state_d = S_TRAP;
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || mem.mem_ready || !wait_st) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.MemWrite = mem_write_c;
  assign ALUctrl      = ALUCTRL_W'(alu_sel);
  assign fault        = (state_q == S_TRAP);
  assign state_o      = state_q;

endmodule
